// File: rtl/code_decoder_pkg.sv
// Shared types and beat generation for the 3-bit code to 8-bit word decoder.
package code_decoder_pkg;
    localparam int CODE_W = 3;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        ONEHOT = 2'b00,
        THERM  = 2'b01,
        WALK   = 2'b10,
        RSVD   = 2'b11
    } mode_t;

    typedef logic state_t;
    localparam state_t IDLE = 1'b0;
    localparam state_t EMIT = 1'b1;

    typedef struct packed {
        logic [CODE_W-1:0] code;
        mode_t             mode;
    } entry_t;

    // Returns {last, data} for beat number idx of entry e.
    function automatic logic [DATA_W:0] beat(input entry_t e, input logic [CODE_W-1:0] idx);
        logic [DATA_W:0] t;
        case (e.mode)
            THERM:   begin
                t = (9'd2 << e.code) - 9'd1;
                return {1'b1, t[DATA_W-1:0]};
            end
            WALK:    return {idx == e.code, 8'd1 << idx};
            default: return {1'b1, 8'd1 << e.code};
        endcase
    endfunction
endpackage

// File: rtl/code_fifo.sv
// Small synchronous FIFO with first-word fall-through read data.
module code_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  T     din,
    output T     dout,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);

    T               mem [DEPTH];
    logic [AW-1:0]  wp, rp;
    logic [AW:0]    cnt;
    logic           do_push, do_pop;

    assign full    = cnt == (AW+1)'(DEPTH);
    assign empty   = cnt == '0;
    // Push is gated by the registered count, so a same-cycle pop never frees a slot early.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rp];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
            cnt <= cnt + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end
endmodule

// File: rtl/code_decoder.sv
// Streaming code decoder: FIFO-buffered codes expanded to one-hot, thermometer
// or walking-bit beats on a registered valid/ready output.
module code_decoder
    import code_decoder_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    input  logic [1:0]        in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              err_mode
);
    entry_t            push_e, head, cur;
    logic              full, empty, pop, xfer;
    state_t            state;
    logic [CODE_W-1:0] idx;
    logic [DATA_W:0]   first, nxt;

    always_comb begin
        push_e.code = in_code;
        push_e.mode = (in_mode == 2'b11) ? ONEHOT : mode_t'(in_mode);
    end

    assign in_ready = !full;
    assign xfer     = out_valid && out_ready;
    assign pop      = !empty && (state == IDLE || (xfer && out_last));
    assign first    = beat(head, '0);
    assign nxt      = beat(cur, idx + 3'd1);

    code_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid),
        .pop   (pop),
        .din   (push_e),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            cur       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            err_mode  <= 1'b0;
        end else begin
            if (in_valid && !full && in_mode == 2'b11) err_mode <= 1'b1;
            // pop is asserted exactly when a new code is loaded below.
            if (pop) begin
                state                <= EMIT;
                cur                  <= head;
                idx                  <= '0;
                {out_last, out_data} <= first;
                out_valid            <= 1'b1;
            end else if (state == EMIT && xfer) begin
                if (!out_last) begin
                    idx                  <= idx + 3'd1;
                    {out_last, out_data} <= nxt;
                end else begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    out_data  <= '0;
                    out_last  <= 1'b0;
                end
            end
        end
    end
endmodule
